inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL: parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL: parameter MAX_WAIT, default 16, max consecutive FETCH cycles without imem_ack before fault (legal range 1..255).
REQ-003 SHALL: parameter NOP_INST, default 32'h0000_0013, inst value after reset (addi x0,x0,0).
REQ-004 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL: imem_req  out  1  fetch request to instruction memory.
REQ-007 SHALL: imem_addr  out  32  fetch address (= pc).
REQ-008 SHALL: imem_ack  in  1  imem_rdata valid this cycle.
REQ-009 SHALL: imem_rdata  in  32  fetched instruction word.
REQ-010 SHALL: inst  out  32  registered instruction to control unit/datapath.
REQ-011 SHALL: pc  out  32  address of inst.
REQ-012 SHALL: inst_valid  out  1  inst/pc hold an instruction under execution.
REQ-013 SHALL: exec_done  in  1  datapath has finished the current instruction; PCSel/alu valid.
REQ-014 SHALL: PCSel  in  1  0: next pc = pc+4; 1: next pc = alu.
REQ-015 SHALL: alu  in  32  branch/jump target from ALU.
REQ-016 SHALL: fetch_err  out  1  sticky: imem timeout.
REQ-017 SHALL: misalign  out  1  sticky: next pc not word-aligned.

Function
REQ-018 SHALL: FSM states IDLE, FETCH, EXEC, HALT; imem_req=1 only in FETCH; inst_valid=1 only in EXEC.
REQ-019 SHALL: IDLE -> FETCH unconditionally on the next edge.
REQ-020 SHALL: FETCH with imem_ack=1 -> inst<=imem_rdata, -> EXEC; fetch latency = ack cycle + 1 (inst_valid rises the cycle after ack).
REQ-021 SHALL: wait counter clears on FETCH entry, increments per FETCH cycle without ack; after MAX_WAIT ack-less cycles -> HALT, fetch_err<=1.
REQ-022 SHALL: ack on exactly the MAX_WAIT-th FETCH cycle is accepted (ack wins over timeout).
REQ-023 SHALL: EXEC holds inst/pc stable until exec_done=1; then pc<=next pc and -> FETCH.
REQ-024 SHALL: next pc = PCSel ? alu : pc+4, 32-bit modulo (pc+4 from 32'hFFFF_FFFC wraps to 0).
REQ-025 SHALL: if next pc[1:0]!=0 at exec_done -> HALT, misalign<=1, pc<=offending address.
REQ-026 SHALL: imem_ack outside FETCH and exec_done outside EXEC are ignored.
REQ-027 SHALL: HALT is terminal until rst; no requests, inst_valid=0.
REQ-028 SHALL: imem_addr = pc combinationally; unchanged across FETCH wait cycles.

Reset
REQ-029 SHALL: on rst edge: state=IDLE, pc=RESET_PC, inst=NOP_INST, counter=0, fetch_err=0, misalign=0.
REQ-030 SHALL: outputs after reset edge: imem_req=0, inst_valid=0, imem_addr=RESET_PC.
REQ-031 SHALL: rst during FETCH/EXEC/HALT aborts; a concurrent imem_ack or exec_done is discarded.

Structure
REQ-032 SHALL: shared package riscv_pkg holds FSM state enum, NOP_INST constant, XLEN=32 and opcode constants shared with Control_Unit.
REQ-033 SHALL: one sub-module pc_next (combinational: pc+4 / alu mux, alignment check).

Verification
REQ-034 SHALL: reset, imem_ack on 1st FETCH cycle with rdata=32'h00500093 -> imem_addr=0, inst=32'h00500093, inst_valid high 1 cycle later.
REQ-035 SHALL: exec_done with PCSel=0 at pc=0x10 -> next imem_addr=0x14; PCSel=1, alu=0x40 -> imem_addr=0x40.
REQ-036 SHALL: MAX_WAIT=4, no ack -> HALT after 4 FETCH cycles, fetch_err=1, imem_req=0; ack on 4th cycle -> EXEC, fetch_err=0.
REQ-037 SHALL: PCSel=1, alu=0x42 -> misalign=1, pc=0x42, HALT, no further imem_req.
REQ-038 SHALL: pc=0xFFFF_FFFC, PCSel=0 -> imem_addr=0x0000_0000.
REQ-039 SHALL: rst asserted concurrently with imem_ack in FETCH -> inst=NOP_INST, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the fetch unit and Control_Unit
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} fetch_state_e;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

// File: rtl/pc_next.sv
// pc_next: selects sequential or ALU target pc and flags misalignment
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic            pc_sel_i,
  output logic [XLEN-1:0] npc_o,
  output logic            misalign_o
);
  always_comb begin
    npc_o      = pc_sel_i ? alu_i : pc_i + 32'd4;
    misalign_o = |npc_o[1:0];
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: multi-cycle instruction fetch FSM with timeout and misalignment halt
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic        PCSel,
  input  logic [31:0] alu,
  output logic        fetch_err,
  output logic        misalign
);
  import riscv_pkg::*;
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, npc;
  logic [7:0]  cnt_q, cnt_d;
  logic        ferr_q, ferr_d, mis_q, mis_d, npc_mis;
  pc_next u_pc_next (
    .pc_i      (pc_q),
    .alu_i     (alu),
    .pc_sel_i  (PCSel),
    .npc_o     (npc),
    .misalign_o(npc_mis)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    ferr_d  = ferr_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        // ack on the final allowed cycle still wins over the timeout
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = EXEC;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = HALT;
          ferr_d  = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
      end
      EXEC: begin
        if (exec_done) begin
          pc_d    = npc;
          state_d = npc_mis ? HALT : FETCH;
          mis_d   = npc_mis;
          cnt_d   = '0;
        end
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
      mis_q   <= mis_d;
    end
  end
  always_comb begin
    imem_req   = state_q == FETCH;
    inst_valid = state_q == EXEC;
    imem_addr  = pc_q;
    pc         = pc_q;
    inst       = inst_q;
    fetch_err  = ferr_q;
    misalign   = mis_q;
  end
endmodule
